// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared encodings and constants for the tick scheduler.
package tick_sched_pkg;
    localparam int MAX_CH = 8;
    localparam int CH_IDX_W = $clog2(MAX_CH);
    typedef enum logic [1:0] {S_RST, S_READY, S_APPLY} cfg_state_e;
    typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/tick_channel.sv
// tick_channel: turns the base tick into a periodic or one-shot enable pulse.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             oneshot_i,
    input  logic             base_tick_i,
    output logic             tick_o,
    output logic             busy_o
);
    ch_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic mode_q, mode_d, tick_q, tick_d;
    logic expire, step;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= MODE_PERIODIC;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    assign step   = state_q == CH_RUN && base_tick_i;
    assign expire = step && cnt_q == '0;

    // A load always wins over an expiry landing in the same cycle.
    always_comb begin
        state_d = load_i ? ((period_i != '0) ? CH_RUN : CH_IDLE)
                : (expire && mode_q == MODE_ONESHOT) ? CH_IDLE
                : state_q;
    end

    always_comb begin
        period_d = load_i ? period_i : period_q;
        mode_d   = load_i ? oneshot_i : mode_q;
        tick_d   = !load_i && expire;
        cnt_d    = load_i ? ((period_i != '0) ? period_i - 1'b1 : '0)
                 : expire ? ((mode_q == MODE_ONESHOT) ? '0 : period_q - 1'b1)
                 : step ? cnt_q - 1'b1
                 : cnt_q;
    end

    always_comb begin
        tick_o = tick_q;
        busy_o = state_q == CH_RUN;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler, config write port and NUM_CH tick channels.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch_i,
    input  logic [CNT_W-1:0]          cfg_period_i,
    input  logic                      cfg_oneshot_i,
    output logic                      base_tick_o,
    output logic [NUM_CH-1:0]         ch_tick_o,
    output logic [NUM_CH-1:0]         ch_busy_o
);
    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic base_q, base_d;
    cfg_state_e state_q, state_d;
    logic [CH_IDX_W-1:0] ch_q;
    logic [CNT_W-1:0] per_q;
    logic os_q, apply, accept;
    logic [NUM_CH-1:0] load;

    always_comb begin
        base_d = pre_q == PRE_W'(PRESCALE - 1);
        pre_d  = base_d ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            base_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            base_q <= base_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RST;
            ch_q    <= '0;
            per_q   <= '0;
            os_q    <= MODE_PERIODIC;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ch_q  <= CH_IDX_W'(cfg_ch_i);
                per_q <= cfg_period_i;
                os_q  <= cfg_oneshot_i;
            end
        end
    end

    always_comb begin
        state_d = (state_q == S_READY && cfg_valid_i) ? S_APPLY : S_READY;
    end

    always_comb begin
        cfg_ready_o = state_q == S_READY;
        apply       = state_q == S_APPLY;
        accept      = cfg_valid_i && cfg_ready_o;
        base_tick_o = base_q;
    end

    // An out-of-range channel index matches no decode bit, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = apply && ch_q == CH_IDX_W'(i);
        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (load[i]),
            .period_i   (per_q),
            .oneshot_i  (os_q),
            .base_tick_i(base_q),
            .tick_o     (ch_tick_o[i]),
            .busy_o     (ch_busy_o[i])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed vectors and multi-cycle sequences for tick_scheduler.
module tb_tick_scheduler;
    logic clk = 0, rst = 1;
    logic cfg_valid = 0, cfg_oneshot = 0, cfg_ready, base_tick;
    logic [1:0] cfg_ch = 0;
    logic [7:0] cfg_period = 0;
    logic [3:0] ch_tick, ch_busy;
    logic v3 = 0, os3 = 0, rdy3, bt3;
    logic [1:0] c3 = 0;
    logic [7:0] p3 = 0;
    logic [2:0] tk3, bs3;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tick_scheduler #(.NUM_CH(4), .PRESCALE(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_ch_i(cfg_ch), .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot),
        .base_tick_o(base_tick), .ch_tick_o(ch_tick), .ch_busy_o(ch_busy)
    );

    tick_scheduler #(.NUM_CH(3), .PRESCALE(4), .CNT_W(8)) dut3 (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(v3), .cfg_ready_o(rdy3),
        .cfg_ch_i(c3), .cfg_period_i(p3), .cfg_oneshot_i(os3),
        .base_tick_o(bt3), .ch_tick_o(tk3), .ch_busy_o(bs3)
    );

    typedef struct packed {
        logic rst; logic v; logic [1:0] ch; logic [7:0] p; logic os;
        logic bt; logic rdy; logic [3:0] tk; logic [3:0] bs;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic r, logic v, logic [1:0] c, logic [7:0] p, logic o,
                                logic b, logic rd, logic [3:0] t, logic [3:0] s);
        mk = '{rst: r, v: v, ch: c, p: p, os: o, bt: b, rdy: rd, tk: t, bs: s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic cfg_write(input logic [1:0] c, input logic [7:0] p, input logic o);
        int n = 0;
        cfg_valid = 1; cfg_ch = c; cfg_period = p; cfg_oneshot = o;
        while (!cfg_ready && n < 10) begin step(); n++; end
        if (!cfg_ready) timeout("cfg_ready_wait");
        step();
        cfg_valid = 0;
        chk("hs_ready_drop", cfg_ready, 0);
    endtask

    // Steps through the apply edge, then counts base ticks seen before each pulse.
    task automatic run_ch(input int c, input int npulse, input int first_bt, input int interval);
        int nbt = 0, got = 0, last = 0, cyc = 0;
        logic pbt = 0, ptk = 0;
        step();
        chk($sformatf("busy_on_ch%0d", c), ch_busy[c], 1);
        while (got < npulse && cyc < 400) begin
            if (ch_tick[c]) begin
                if (got == 0) begin
                    chk($sformatf("first_nbt_ch%0d", c), nbt, first_bt);
                    chk($sformatf("first_prev_bt_ch%0d", c), pbt, 1);
                end else begin
                    chk($sformatf("interval_ch%0d", c), cyc - last, interval);
                end
                chk($sformatf("width_ch%0d", c), ptk, 0);
                last = cyc;
                got++;
            end
            if (base_tick) nbt++;
            pbt = base_tick;
            ptk = ch_tick[c];
            if (got < npulse) begin step(); cyc++; end
        end
        if (got < npulse) timeout($sformatf("pulses_ch%0d", c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
        tbl[6]  = mk(0, 1, 1, 1, 0, 0, 0, 4'h0, 4'h0);
        tbl[7]  = mk(0, 1, 2, 2, 1, 0, 1, 4'h0, 4'h2);
        tbl[8]  = mk(0, 1, 2, 2, 1, 1, 0, 4'h0, 4'h2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h6);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h6);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h6);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 4'h0, 4'h6);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h6);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h6);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h6);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 1, 4'h0, 4'h6);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 4'h6, 4'h2);
        tbl[18] = mk(0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h2);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
        tbl[21] = mk(0, 1, 3, 0, 0, 0, 0, 4'h0, 4'h0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; cfg_valid = tbl[i].v; cfg_ch = tbl[i].ch;
            cfg_period = tbl[i].p; cfg_oneshot = tbl[i].os;
            step();
            chk($sformatf("v%0d_base_tick", i), base_tick, tbl[i].bt);
            chk($sformatf("v%0d_cfg_ready", i), cfg_ready, tbl[i].rdy);
            chk($sformatf("v%0d_ch_tick", i), ch_tick, tbl[i].tk);
            chk($sformatf("v%0d_ch_busy", i), ch_busy, tbl[i].bs);
        end
        cfg_valid = 0;

        // Periodic ch0, then a write timed so its apply lands on the expiring base tick.
        cfg_write(0, 3, 0);
        run_ch(0, 5, 3, 12);
        repeat (10) step();
        cfg_write(0, 3, 0);
        chk("collision_align_bt", base_tick, 1);
        run_ch(0, 1, 3, 0);

        cfg_write(1, 2, 1);
        run_ch(1, 1, 2, 0);
        chk("oneshot_busy_fall", ch_busy[1], 0);
        n = 0;
        repeat (100) begin step(); if (ch_tick[1]) n++; end
        chk("oneshot_no_more", n, 0);

        cfg_write(2, 5, 0);
        step();
        chk("ch2_run_busy", ch_busy[2], 1);
        repeat (8) step();
        cfg_write(2, 0, 0);
        step();
        chk("ch2_stop_busy", ch_busy[2], 0);
        n = 0;
        repeat (60) begin step(); if (ch_tick[2]) n++; end
        chk("ch2_stop_no_tick", n, 0);
        cfg_write(2, 1, 0);
        run_ch(2, 4, 1, 4);

        cfg_write(1, 1, 0);
        step();
        cfg_write(3, 2, 0);
        step();
        chk("all_busy", ch_busy, 4'hf);
        n = 0;
        while (!base_tick && n < 8) begin step(); n++; end
        if (!base_tick) timeout("midrst_bt_wait");
        rst = 1;
        step();
        rst = 0;
        chk("midrst_tick", ch_tick, 0);
        chk("midrst_busy", ch_busy, 0);
        chk("midrst_bt", base_tick, 0);
        chk("midrst_ready", cfg_ready, 0);
        step();
        chk("midrst_ready_back", cfg_ready, 1);
        n = 0;
        repeat (50) begin step(); if (ch_tick != 0 || ch_busy != 0) n++; end
        chk("midrst_quiet", n, 0);

        chk("oor_ready_pre", rdy3, 1);
        v3 = 1; c3 = 3; p3 = 1; os3 = 0;
        step();
        v3 = 0;
        chk("oor_accepted", rdy3, 0);
        n = 0;
        repeat (20) begin step(); if (tk3 != 0 || bs3 != 0) n++; end
        chk("oor_no_change", n, 0);
        v3 = 1; c3 = 2; p3 = 1;
        step();
        v3 = 0;
        step();
        chk("n3_ch2_busy", bs3, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Central timing controller for the game logic. One free-running prescaler produces a base tick, and NUM_CH independent channels turn that tick into single-cycle enable pulses (cursor blink, 7-seg refresh, hit animation, turn timeout).
- Channels are configured at runtime through a valid/ready write port.
- Replaces scattered derived-clock dividers: everything stays on clk, and consumers gate on ch_tick.

Parameters:
- NUM_CH, 4, number of tick channels (2..8)
- PRESCALE, 100000, clk cycles per base tick (100 MHz -> 1 kHz); must be >= 2
- CNT_W, 16, width of channel period/counter

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  scheduler can accept a config write
- cfg_ch  in  $clog2(NUM_CH)  target channel index
- cfg_period  in  CNT_W  period in base ticks; 0 = stop channel
- cfg_oneshot  in  1  1 = fire once then idle, 0 = periodic
- base_tick  out  1  one-cycle pulse every PRESCALE clks
- ch_tick  out  NUM_CH  one-cycle enable pulse per channel
- ch_busy  out  NUM_CH  channel is in RUN

Behaviour:
- Reset: prescaler = 0, all channels IDLE, counters = 0, base_tick = 0, ch_tick = 0, ch_busy = 0, cfg_ready = 0, config FSM in S_RST. All values are held while rst = 1.
- Prescaler counts 0..PRESCALE-1 and wraps to 0. base_tick (registered) is high in the cycle after the count equals PRESCALE-1, giving exactly one pulse per PRESCALE clks.
- Config FSM:
  - S_RST -> S_READY on the first cycle with rst = 0.
  - S_READY: cfg_ready = 1. On cfg_valid & cfg_ready, latch cfg_ch, cfg_period and cfg_oneshot, then go to S_APPLY.
  - S_APPLY: cfg_ready = 0. Write the latched fields to the target channel, then return to S_READY.
  - Net effect: at most one write per 2 cycles. The channel sees the new config 1 cycle after the handshake.
- cfg_ch >= NUM_CH: the handshake completes and the write is silently dropped.
- Channel FSM (per channel):
  - IDLE: ch_busy = 0.
  - Apply with period P > 0: cnt <= P-1, state RUN, ch_busy = 1 from the next cycle.
  - Apply with P = 0: state IDLE, cnt = 0. Any pending expiry is cancelled.
  - RUN, on a base_tick cycle:
    - If cnt == 0, the channel expires: ch_tick pulses high in the next cycle.
      - Periodic: cnt <= P-1 and the channel stays in RUN.
      - One-shot: the channel goes IDLE, and ch_busy falls in the same cycle ch_tick rises.
    - Otherwise cnt decrements.
  - RUN, no base_tick: cnt holds.
- Period semantics: a channel loaded with P emits its first ch_tick on the P-th base_tick after the apply cycle, then every P base_ticks. P = 1 therefore ticks on every base_tick.
- Simultaneous apply and base_tick on the same channel: the apply wins, the pending expiry is discarded, and no ch_tick is produced for that base_tick.
- Re-writing a running channel restarts its count immediately with the new period and mode.
- Channels are independent. Several ch_tick bits may be high in the same cycle.
- rst asserted mid-operation returns everything to reset values on the next edge. No tick is emitted for an expiry in flight.
- The counter is unsigned CNT_W bits with no overflow path. cnt never goes below 0 because the decrement happens only when cnt != 0.

Decomposition:
- Package tick_sched_pkg holds:
  - config FSM state encoding (S_RST, S_READY, S_APPLY)
  - channel state encoding (CH_IDLE, CH_RUN)
  - MODE_PERIODIC = 0, MODE_ONESHOT = 1
  - helper constant CH_IDX_W
- Sub-module tick_channel: one instance per channel via a generate loop.
  - Inputs: clk, rst, load, period, oneshot, base_tick.
  - Outputs: tick, busy.
- The top level holds the prescaler, config FSM and decode.

Test Plan (bench uses PRESCALE = 4, NUM_CH = 4, CNT_W = 8):
- Reset release: hold rst 5 cycles, then release -> all outputs 0 during rst; cfg_ready = 1 on the first cycle after release; base_tick first high 4 clks after release, then every 4 clks.
- Periodic: write ch0, P = 3, periodic -> ch_busy[0] = 1; ch_tick[0] pulses 1 cycle wide on the 3rd base_tick after apply, then every 12 clks; 5 consecutive pulses checked.
- One-shot: write ch1, P = 2, oneshot = 1 -> exactly one ch_tick[1], 8 clks after apply (±alignment to base_tick); ch_busy[1] falls with it; no further pulses in 100 clks.
- Stop/restart: ch2 running with P = 5; write P = 0 -> no ch_tick[2] afterwards and ch_busy[2] = 0. Write P = 1 -> ch_tick[2] on every base_tick.
- Collision: time a write to ch0 so its apply coincides with ch0's expiring base_tick -> no ch_tick[0] that period; next tick P base_ticks later.
- Handshake/invalid: back-to-back cfg_valid -> cfg_ready alternates 1/0; a write with cfg_ch = 3 while ch3 is idle, then cfg_ch out of range (widen in a NUM_CH = 3 build) -> accepted, no channel change.
- Mid-run reset: pulse rst for 1 cycle with all channels running -> all ch_busy = 0, no ticks until reconfigured.
